spi_slave_drive: RTL and testbench



---
 rtl/spi_slave_drive.sv | 97 +++++++++
 tb/tb_spi_slave_drive.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_drive.sv
// spi_slave_drive: SPI responder oversampling SCLK/CS/MOSI in i_clk, with one-entry TX holding buffer.
module spi_slave_drive #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CPOL = 0,
  parameter int P_CPHA = 0,
  parameter logic [P_DATA_WIDTH-1:0] P_IDLE_WORD = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_spi_clk,
  input  logic                    i_spi_cs,
  input  logic                    i_spi_mosi,
  output logic                    o_spi_miso,
  input  logic [P_DATA_WIDTH-1:0] i_user_data,
  input  logic                    i_user_valid,
  output logic                    o_ready,
  output logic [P_DATA_WIDTH-1:0] o_user_data,
  output logic                    o_user_valid,
  output logic                    o_underrun,
  output logic                    o_frame_err
);
  localparam int W = P_DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic POL = (P_CPOL != 0);
  localparam logic PHA = (P_CPHA != 0);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [W-1:0] tx_sr, hold, rx_sr;
  logic [CW-1:0] cnt;
  logic und_pend;
  logic cs_fall, cs_rise, en, lead, trail, sample_e, shift_e, load_e, accept, last;
  assign cs_fall = cs_s[2] & ~cs_s[1];
  assign cs_rise = ~cs_s[2] & cs_s[1];
  assign en = (state == ACTIVE) && !cs_s[1];
  assign lead = en && (sclk_s[2] == POL) && (sclk_s[1] != POL);
  assign trail = en && (sclk_s[2] != POL) && (sclk_s[1] == POL);
  assign sample_e = PHA ? trail : lead;
  assign shift_e = PHA ? lead : trail;
  assign load_e = PHA ? (lead && cnt == '0) : (cs_fall || (trail && cnt == '0));
  assign accept = i_user_valid && (o_ready || load_e);
  assign last = cnt == CW'(W - 1);
  assign o_spi_miso = tx_sr[W-1];
  // An idle word loaded at the end of a word only counts as an underrun once the master clocks it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_s <= {3{POL}};
      cs_s <= 3'b111;
      mosi_s <= '0;
      state <= IDLE;
      tx_sr <= '0;
      hold <= '0;
      rx_sr <= '0;
      cnt <= '0;
      und_pend <= 1'b0;
      o_ready <= 1'b1;
      o_user_data <= '0;
      o_user_valid <= 1'b0;
      o_underrun <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], i_spi_clk};
      cs_s <= {cs_s[1:0], i_spi_cs};
      mosi_s <= {mosi_s[0], i_spi_mosi};
      o_user_valid <= 1'b0;
      o_underrun <= 1'b0;
      o_frame_err <= 1'b0;
      if (accept) hold <= i_user_data;
      o_ready <= accept ? 1'b0 : load_e ? 1'b1 : o_ready;
      state <= cs_fall ? ACTIVE : cs_rise ? IDLE : state;
      if (cs_rise) begin
        tx_sr <= '0;
        rx_sr <= '0;
        cnt <= '0;
        und_pend <= 1'b0;
        o_frame_err <= cnt != '0;
      end else begin
        if (load_e) begin
          tx_sr <= o_ready ? P_IDLE_WORD : hold;
          o_underrun <= o_ready && (PHA || cs_fall);
          und_pend <= o_ready && !PHA && !cs_fall;
        end else if (shift_e) begin
          tx_sr <= tx_sr << 1;
        end
        if (sample_e) begin
          rx_sr <= {rx_sr[W-2:0], mosi_s[1]};
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) o_user_data <= {rx_sr[W-2:0], mosi_s[1]};
          o_user_valid <= last;
          if (und_pend) o_underrun <= 1'b1;
          und_pend <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_drive.sv
// tb_spi_slave_drive: directed bench for a mode-0 and a mode-3 responder driven by a behavioural master.
module tb_spi_slave_drive;
  localparam int H = 6;
  logic clk = 0;
  logic rst;
  logic [1:0] sclk, cs, mosi, uval;
  logic [7:0] udin0, udin1;
  wire [1:0] miso, rdy, oval, und, ferr;
  wire [7:0] udout0, udout1;
  int checks = 0, failures = 0;
  int nv0 = 0, nv1 = 0, nu0 = 0, nf0 = 0;
  logic [15:0] vdat0 = '0;
  logic [15:0] cap;
  int bi = -1;
  int v, u, f;

  always #5 clk = ~clk;

  spi_slave_drive #(.P_DATA_WIDTH(8)) u_m0 (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sclk[0]), .i_spi_cs(cs[0]), .i_spi_mosi(mosi[0]),
    .o_spi_miso(miso[0]), .i_user_data(udin0), .i_user_valid(uval[0]), .o_ready(rdy[0]),
    .o_user_data(udout0), .o_user_valid(oval[0]), .o_underrun(und[0]), .o_frame_err(ferr[0])
  );

  spi_slave_drive #(.P_DATA_WIDTH(8), .P_CPOL(1), .P_CPHA(1)) u_m3 (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sclk[1]), .i_spi_cs(cs[1]), .i_spi_mosi(mosi[1]),
    .o_spi_miso(miso[1]), .i_user_data(udin1), .i_user_valid(uval[1]), .o_ready(rdy[1]),
    .o_user_data(udout1), .o_user_valid(oval[1]), .o_underrun(und[1]), .o_frame_err(ferr[1])
  );

  always @(posedge clk) begin
    if (oval[0]) begin
      nv0 <= nv0 + 1;
      vdat0 <= {vdat0[7:0], udout0};
    end
    if (oval[1]) nv1 <= nv1 + 1;
    if (und[0]) nu0 <= nu0 + 1;
    if (ferr[0]) nf0 <= nf0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int m, input logic [7:0] d);
    if (m == 0) udin0 = d; else udin1 = d;
    uval[m] = 1'b1;
    wt(1);
    uval[m] = 1'b0;
  endtask

  // m=0: CPOL0/CPHA0 master, m=1: CPOL1/CPHA1 master; bits sent MSB first from d[15]
  task automatic frame(input int m, input int nbits, input logic [15:0] d);
    cap = '0;
    cs[m] = 1'b0;
    wt(H);
    for (int i = 0; i < nbits; i++) begin
      bi = i;
      if (m == 0) begin
        mosi[m] = d[15-i];
        wt(H);
        cap = {cap[14:0], miso[m]};
        sclk[m] = 1'b1;
        wt(H);
        sclk[m] = 1'b0;
      end else begin
        sclk[m] = 1'b0;
        mosi[m] = d[15-i];
        wt(H);
        cap = {cap[14:0], miso[m]};
        sclk[m] = 1'b1;
        wt(H);
      end
    end
    wt(H);
    cs[m] = 1'b1;
    mosi[m] = 1'b0;
    wt(H);
    bi = -1;
  endtask

  initial begin
    rst = 1'b1;
    sclk = 2'b10;
    cs = 2'b11;
    mosi = '0;
    uval = '0;
    udin0 = '0;
    udin1 = '0;
    wt(3);
    rst = 1'b0;
    wt(4);
    chk("rst_miso", miso[0], 1'b0);
    chk("rst_ready", rdy[0], 1'b1);
    chk("rst_udata", udout0, 8'h00);
    chk("rst_uvalid", oval[0], 1'b0);
    chk("rst_underrun", und[0], 1'b0);
    chk("rst_frame_err", ferr[0], 1'b0);
    chk("rst_ready_m3", rdy[1], 1'b1);

    wr(0, 8'hA5);
    chk("wr_ready_clr", rdy[0], 1'b0);
    v = nv0; u = nu0; f = nf0;
    frame(0, 8, 16'h3C00);
    chk("m0_miso", cap[7:0], 8'hA5);
    chk("m0_udata", udout0, 8'h3C);
    chk("m0_nvalid", nv0 - v, 1);
    chk("m0_ready", rdy[0], 1'b1);
    chk("m0_nunder", nu0 - u, 0);
    chk("m0_nferr", nf0 - f, 0);

    wr(0, 8'h81);
    v = nv0; u = nu0;
    fork
      frame(0, 16, 16'h1122);
      begin
        for (int k = 0; k < 60 && !rdy[0]; k++) wt(1);
        chk("b2b_ready_wait", rdy[0], 1'b1);
        wr(0, 8'h7E);
      end
    join
    chk("b2b_miso", cap, 16'h817E);
    chk("b2b_words", vdat0, 16'h1122);
    chk("b2b_nvalid", nv0 - v, 2);
    chk("b2b_nunder", nu0 - u, 0);
    chk("b2b_ready", rdy[0], 1'b1);

    v = nv0; u = nu0;
    frame(0, 8, 16'hF000);
    chk("und_miso", cap[7:0], 8'h00);
    chk("und_nunder", nu0 - u, 1);
    chk("und_udata", udout0, 8'hF0);
    chk("und_nvalid", nv0 - v, 1);

    v = nv0; f = nf0;
    frame(0, 5, 16'hA800);
    chk("abort_nferr", nf0 - f, 1);
    chk("abort_nvalid", nv0 - v, 0);
    chk("abort_udata", udout0, 8'hF0);
    v = nv0; f = nf0;
    frame(0, 8, 16'h5500);
    chk("post_abort_udata", udout0, 8'h55);
    chk("post_abort_nvalid", nv0 - v, 1);
    chk("post_abort_nferr", nf0 - f, 0);

    wr(1, 8'hC3);
    chk("m3_wr_ready", rdy[1], 1'b0);
    v = nv1;
    frame(1, 8, 16'h9600);
    chk("m3_miso", cap[7:0], 8'hC3);
    chk("m3_udata", udout1, 8'h96);
    chk("m3_nvalid", nv1 - v, 1);
    chk("m3_ready", rdy[1], 1'b1);

    wr(0, 8'hFF);
    fork
      frame(0, 8, 16'h0F00);
      begin
        for (int k = 0; k < 2000 && bi != 3; k++) wt(1);
        chk("rst_bit3_reached", bi, 3);
        wt(2);
        chk("pre_rst_miso", miso[0], 1'b1);
        rst = 1'b1;
        wt(1);
        chk("mid_rst_miso", miso[0], 1'b0);
        chk("mid_rst_ready", rdy[0], 1'b1);
        chk("mid_rst_udata", udout0, 8'h00);
        chk("mid_rst_uvalid", oval[0], 1'b0);
        chk("mid_rst_underrun", und[0], 1'b0);
        chk("mid_rst_frame_err", ferr[0], 1'b0);
      end
    join
    rst = 1'b0;
    wt(4);
    chk("post_rst_ready", rdy[0], 1'b1);
    wr(0, 8'h12);
    chk("post_rst_accept", rdy[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
